axi_read_responder: RTL and testbench



---
 rtl/axi_pkg.sv | 43 ++++
 rtl/axi_read_responder_if.sv | 34 +++
 rtl/axi_burst_addr.sv | 34 +++
 rtl/axi_read_responder.sv | 166 ++++++++++++++++
 tb/tb_axi_read_responder.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, FSM state codes and burst legality check.
// Imported by the read responder and its burst address helper.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_ASSERT = 2'd2;

  localparam int unsigned BOUNDARY_4K = 4096;

  // Burst is unserviceable: reserved type, oversize beat,
  // illegal wrap length or an INCR crossing a 4 KB page.
  function automatic logic burst_err(
    input logic [11:0] a,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic [16:0] span;
    logic        err;
    span = 17'(a) + ((17'(len) + 17'd1) << size);
    err  = 1'b0;
    if (burst == 2'b11)
      err = 1'b1;
    if (size > 3'd3)
      err = 1'b1;
    if (burst == BURST_WRAP &&
        !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))
      err = 1'b1;
    if (burst == BURST_INCR &&
        span > 17'(BOUNDARY_4K))
      err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/axi_read_responder_if.sv
// AXI4 read address / read data channel bundle.
// slave: responder side; master: interconnect / initiator side.
interface axi_read_responder_if #(
  parameter int AW = 32,
  parameter int DW = 64
) ();

  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rlast;
  logic          axi_rvalid;
  logic          axi_rready;

  modport slave (
    input  axi_araddr, axi_arlen, axi_arsize,
    input  axi_arburst, axi_arvalid, axi_rready,
    output axi_arready, axi_rdata, axi_rresp,
    output axi_rlast, axi_rvalid
  );

  modport master (
    output axi_araddr, axi_arlen, axi_arsize,
    output axi_arburst, axi_arvalid, axi_rready,
    input  axi_arready, axi_rdata, axi_rresp,
    input  axi_rlast, axi_rvalid
  );

endinterface

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// in: addr_i, size_i, len_i, burst_i; out: next_o (AW-bit truncating).
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr_i,
  input  logic [2:0]    size_i,
  input  logic [7:0]    len_i,
  input  logic [1:0]    burst_i,
  output logic [AW-1:0] next_o
);

  logic [AW-1:0] bytes;
  logic [AW-1:0] total;

  assign bytes = AW'(1) << size_i;
  assign total = (AW'(len_i) + AW'(1)) << size_i;

  always_comb begin
    next_o = addr_i;
    unique case (burst_i)
      BURST_FIXED: next_o = addr_i;
      BURST_INCR:
        next_o = (addr_i & ~(bytes - AW'(1))) + bytes;
      BURST_WRAP:
        next_o = (addr_i & ~(total - AW'(1))) |
                 ((addr_i + bytes) & (total - AW'(1)));
      default: next_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read slave: accepts one AR, fetches each beat from a backing store, returns R.
// Ports: axi_aclk, rst, axi (slave modport), rd_req/rd_addr/rd_data_in/rd_data_valid.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          axi_aclk,
  input  logic          rst,
  axi_read_responder_if.slave axi,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data_in,
  input  logic          rd_data_valid
);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    burst_q, burst_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic          rlast_q, rlast_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] next_addr;

  axi_burst_addr #(.AW(AW)) u_addr (
    .addr_i  (addr_q),
    .size_i  (size_q),
    .len_i   (len_q),
    .burst_i (burst_q),
    .next_o  (next_addr)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arready_q && axi.axi_arvalid) begin
          addr_d    = axi.axi_araddr;
          len_d     = axi.axi_arlen;
          size_d    = axi.axi_arsize;
          burst_d   = axi.axi_arburst;
          cnt_d     = 8'd0;
          arready_d = 1'b0;
          err_d     = burst_err(axi.axi_araddr[11:0],
                                axi.axi_arlen,
                                axi.axi_arsize,
                                axi.axi_arburst);
          if (err_d) begin
            // Error bursts skip the store entirely.
            state_d  = ST_ASSERT;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            rlast_d  = (axi.axi_arlen == 8'd0);
          end else begin
            state_d   = ST_FETCH;
            rd_req_d  = 1'b1;
            rd_addr_d = axi.axi_araddr;
          end
        end
      end
      ST_FETCH: begin
        if (rd_data_valid) begin
          rdata_d  = rd_data_in;
          rresp_d  = RESP_OKAY;
          rvalid_d = 1'b1;
          rlast_d  = (cnt_q == len_q);
          rd_req_d = 1'b0;
          state_d  = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (axi.axi_rready) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            state_d   = ST_IDLE;
            arready_d = 1'b1;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = next_addr;
            if (err_q) begin
              // Next SLVERR beat is presented back-to-back.
              rvalid_d = 1'b1;
              rlast_d  = (cnt_q + 8'd1 == len_q);
            end else begin
              state_d   = ST_FETCH;
              rd_req_d  = 1'b1;
              rd_addr_d = next_addr;
            end
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rd_req_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign axi.axi_arready = arready_q;
  assign axi.axi_rvalid  = rvalid_q;
  assign axi.axi_rlast   = rlast_q;
  assign axi.axi_rresp   = rresp_q;
  assign axi.axi_rdata   = rdata_q;
  assign rd_req          = rd_req_q;
  assign rd_addr         = rd_addr_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Scoreboard bench for axi_read_responder: directed AR bursts,
// a latency-programmable backing store and an R-channel monitor.
module tb_axi_read_responder;
  import axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_read_responder_if #(.AW(AW), .DW(DW)) axi ();

  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data_in;
  logic          rd_data_valid;

  axi_read_responder #(.AW(AW), .DW(DW)) dut (
    .axi_aclk      (clk),
    .rst           (rst),
    .axi           (axi.slave),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_data_in    (rd_data_in),
    .rd_data_valid (rd_data_valid)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_r[$];
  logic [31:0] exp_a[$];
  int n_tests = 0;
  int n_fail = 0;
  int beats_seen = 0;
  int lat = 2;

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic fail_now(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [63:0] mem(logic [31:0] a);
    return {a, 32'h0} | (64'hA0 + 64'(a[7:3]));
  endfunction

  task automatic push_r(logic [63:0] d, logic [1:0] r, logic l);
    beat_t b;
    b.data = d;
    b.resp = r;
    b.last = l;
    exp_r.push_back(b);
  endtask

  // Backing store: answers each rd_req after lat cycles.
  initial begin
    logic [31:0] a;
    rd_data_valid = 1'b0;
    rd_data_in = '0;
    forever begin
      @(posedge clk); #1;
      if (rd_req && !rst) begin
        if (exp_a.size() == 0)
          fail_now("unexpected rd_req");
        else
          chk("rd_addr", 64'(rd_addr), 64'(exp_a.pop_front()));
        a = rd_addr;
        repeat (lat - 1) @(posedge clk);
        #1;
        rd_data_in = mem(a);
        rd_data_valid = 1'b1;
        @(posedge clk); #1;
        rd_data_valid = 1'b0;
      end
    end
  end

  // R-channel monitor.
  initial begin
    logic        held;
    logic [63:0] hd;
    logic        hl;
    beat_t       e;
    held = 1'b0;
    hd = '0;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (axi.axi_rvalid || rd_req)
        chk("arready low while busy", 64'(axi.axi_arready), 64'd0);
      if (axi.axi_rvalid) begin
        chk("no rd_req while rvalid", 64'(rd_req), 64'd0);
        if (held) begin
          chk("rdata stable", axi.axi_rdata, hd);
          chk("rlast stable", 64'(axi.axi_rlast), 64'(hl));
        end
        if (axi.axi_rready) begin
          beats_seen++;
          held = 1'b0;
          if (exp_r.size() == 0)
            fail_now("unexpected R beat");
          else begin
            e = exp_r.pop_front();
            chk("rdata", axi.axi_rdata, e.data);
            chk("rresp", 64'(axi.axi_rresp), 64'(e.resp));
            chk("rlast", 64'(axi.axi_rlast), 64'(e.last));
          end
        end else begin
          held = 1'b1;
          hd = axi.axi_rdata;
          hl = axi.axi_rlast;
        end
      end else
        held = 1'b0;
    end
  end

  task automatic send_ar(logic [31:0] a, logic [7:0] l,
                         logic [2:0] s, logic [1:0] b);
    int n;
    n = 0;
    axi.axi_araddr = a;
    axi.axi_arlen = l;
    axi.axi_arsize = s;
    axi.axi_arburst = b;
    axi.axi_arvalid = 1'b1;
    @(negedge clk);
    while (!axi.axi_arready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!axi.axi_arready)
      fail_now("AR handshake timeout");
    @(posedge clk); #1;
    axi.axi_arvalid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_r.size() == 0 && exp_a.size() == 0 &&
             axi.axi_arready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300)
      fail_now({name, " completion timeout"});
    chk({name, " arready back"}, 64'(axi.axi_arready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    axi.axi_araddr = '0;
    axi.axi_arlen = '0;
    axi.axi_arsize = '0;
    axi.axi_arburst = '0;
    axi.axi_arvalid = 1'b0;
    axi.axi_rready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset arready", 64'(axi.axi_arready), 64'd1);
    chk("reset rvalid", 64'(axi.axi_rvalid), 64'd0);
    chk("reset rlast", 64'(axi.axi_rlast), 64'd0);
    chk("reset rresp", 64'(axi.axi_rresp), 64'd0);
    chk("reset rdata", axi.axi_rdata, 64'd0);
    chk("reset rd_req", 64'(rd_req), 64'd0);
    chk("reset rd_addr", 64'(rd_addr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // INCR 0x100 len 3
    exp_a.push_back(32'h100);
    exp_a.push_back(32'h108);
    exp_a.push_back(32'h110);
    exp_a.push_back(32'h118);
    push_r(64'h00000100_000000A0, RESP_OKAY, 1'b0);
    push_r(64'h00000108_000000A1, RESP_OKAY, 1'b0);
    push_r(64'h00000110_000000A2, RESP_OKAY, 1'b0);
    push_r(64'h00000118_000000A3, RESP_OKAY, 1'b1);
    send_ar(32'h100, 8'd3, 3'd3, BURST_INCR);
    wait_idle("incr");

    // WRAP 0x118 len 3
    exp_a.push_back(32'h118);
    exp_a.push_back(32'h100);
    exp_a.push_back(32'h108);
    exp_a.push_back(32'h110);
    push_r(64'h00000118_000000A3, RESP_OKAY, 1'b0);
    push_r(64'h00000100_000000A0, RESP_OKAY, 1'b0);
    push_r(64'h00000108_000000A1, RESP_OKAY, 1'b0);
    push_r(64'h00000110_000000A2, RESP_OKAY, 1'b1);
    send_ar(32'h118, 8'd3, 3'd3, BURST_WRAP);
    wait_idle("wrap");

    // Backpressure on beat 2
    exp_a.push_back(32'h300);
    exp_a.push_back(32'h308);
    exp_a.push_back(32'h310);
    push_r(64'h00000300_000000A0, RESP_OKAY, 1'b0);
    push_r(64'h00000308_000000A1, RESP_OKAY, 1'b0);
    push_r(64'h00000310_000000A2, RESP_OKAY, 1'b1);
    base = beats_seen;
    send_ar(32'h300, 8'd2, 3'd3, BURST_INCR);
    n = 0;
    while (beats_seen < base + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    axi.axi_rready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!axi.axi_rvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!axi.axi_rvalid)
      fail_now("stall beat timeout");
    repeat (5) @(posedge clk);
    #1;
    chk("stall rvalid held", 64'(axi.axi_rvalid), 64'd1);
    axi.axi_rready = 1'b1;
    @(posedge clk); #1;
    chk("stall beat done", 64'(axi.axi_rvalid), 64'd0);
    wait_idle("stall");

    // Reserved burst type
    push_r(64'd0, RESP_SLVERR, 1'b0);
    push_r(64'd0, RESP_SLVERR, 1'b0);
    push_r(64'd0, RESP_SLVERR, 1'b1);
    send_ar(32'h100, 8'd2, 3'd3, 2'b11);
    wait_idle("err burst");

    // INCR crossing 4 KB
    push_r(64'd0, RESP_SLVERR, 1'b0);
    push_r(64'd0, RESP_SLVERR, 1'b1);
    send_ar(32'hFF8, 8'd1, 3'd3, BURST_INCR);
    wait_idle("err 4k");

    // Reset during FETCH of beat 1
    lat = 4;
    exp_a.push_back(32'h200);
    exp_a.push_back(32'h208);
    push_r(64'h00000200_000000A0, RESP_OKAY, 1'b0);
    send_ar(32'h200, 8'd7, 3'd3, BURST_INCR);
    n = 0;
    @(negedge clk);
    while (!(rd_req && rd_addr == 32'h208) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100)
      fail_now("beat 1 fetch timeout");
    #2;
    rst = 1'b1;
    #1;
    chk("async rst rvalid", 64'(axi.axi_rvalid), 64'd0);
    chk("async rst rd_req", 64'(rd_req), 64'd0);
    chk("async rst arready", 64'(axi.axi_arready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    lat = 2;
    exp_a.push_back(32'h180);
    exp_a.push_back(32'h188);
    push_r(64'h00000180_000000B0, RESP_OKAY, 1'b0);
    push_r(64'h00000188_000000B1, RESP_OKAY, 1'b1);
    send_ar(32'h180, 8'd1, 3'd3, BURST_INCR);
    wait_idle("after reset");

    // FIXED len 0, second AR queued behind it
    exp_a.push_back(32'h40);
    exp_a.push_back(32'h100);
    push_r(64'h00000040_000000A8, RESP_OKAY, 1'b1);
    push_r(64'h00000100_000000A0, RESP_OKAY, 1'b1);
    send_ar(32'h40, 8'd0, 3'd3, BURST_FIXED);
    base = beats_seen;
    send_ar(32'h100, 8'd0, 3'd3, BURST_INCR);
    chk("2nd AR after 1st beat", 64'(beats_seen), 64'(base + 1));
    wait_idle("fixed pair");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
